// File: rtl/predictor_update_arbiter_if.sv
// predictor_update_arbiter_if: request, handshake and predictor-update bundle for the update arbiter
interface predictor_update_arbiter_if #(parameter int PTR_W = 2);
    logic             rdy;
    logic             flush;
    logic             a_valid;
    logic [31:0]      a_pc;
    logic             a_taken;
    logic             a_ready;
    logic             b_valid;
    logic [31:0]      b_pc;
    logic             b_taken;
    logic             b_ready;
    logic             update;
    logic [31:0]      update_pc;
    logic             update_result;
    logic [PTR_W:0]   count;

    modport master (
        output rdy, flush, a_valid, a_pc, a_taken, b_valid, b_pc, b_taken,
        input  a_ready, b_ready, update, update_pc, update_result, count
    );

    modport slave (
        input  rdy, flush, a_valid, a_pc, a_taken, b_valid, b_pc, b_taken,
        output a_ready, b_ready, update, update_pc, update_result, count
    );
endinterface

// File: rtl/predictor_update_arbiter.sv
// predictor_update_arbiter: merges commit (A) and resolve (B) updates through a small queue into one predictor update per cycle
module predictor_update_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    predictor_update_arbiter_if.slave      bus
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [32:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             rr;
    logic             update;
    logic [31:0]      update_pc;
    logic             update_result;

    logic [PTR_W:0]   free;
    logic             open;
    logic             both;
    logic             one_slot;
    logic             push_a;
    logic             push_b;
    logic             pop;

    // Slot accounting uses only the registered count, so a pop never frees a slot in the same cycle
    always_comb begin
        free     = FULL - count;
        open     = rst & bus.rdy & ~bus.flush;
        both     = bus.a_valid & bus.b_valid;
        one_slot = free == (PTR_W + 1)'(1);
        bus.a_ready = open & (free >= (PTR_W + 1)'(2) | (one_slot & (~both | ~rr)));
        bus.b_ready = open & (free >= (PTR_W + 1)'(2) | (one_slot & (~both | rr)));
        push_a   = bus.a_valid & bus.a_ready;
        push_b   = bus.b_valid & bus.b_ready;
        pop      = bus.rdy & ~bus.flush & (count != '0);
    end

    // Accepted entries land at tail; when both are taken A goes first so B follows it
    always_ff @(posedge clk) begin
        if (push_a) mem[tail] <= {bus.a_pc, bus.a_taken};
        if (push_b) mem[tail + PTR_W'(push_a)] <= {bus.b_pc, bus.b_taken};
    end

    // Queue pointers, occupancy, round-robin bit and the registered update output
    always_ff @(posedge clk) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rr            <= 1'b0;
            update        <= 1'b0;
            update_pc     <= '0;
            update_result <= 1'b0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                update <= 1'b0;
            end else begin
                tail  <= tail + PTR_W'(push_a) + PTR_W'(push_b);
                count <= count + (PTR_W + 1)'(push_a) + (PTR_W + 1)'(push_b) - (PTR_W + 1)'(pop);
                update <= pop;
                if (pop) begin
                    update_pc     <= mem[head][32:1];
                    update_result <= mem[head][0];
                    head          <= head + PTR_W'(1);
                end
                if (one_slot && both) rr <= ~rr;
            end
        end
    end

    assign bus.count         = count;
    assign bus.update        = update;
    assign bus.update_pc     = update_pc;
    assign bus.update_result = update_result;
endmodule

// File: tb/tb_predictor_update_arbiter.sv
// tb_predictor_update_arbiter: random and directed stimulus checked against a queue-based reference model
module tb_predictor_update_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    predictor_update_arbiter_if #(.PTR_W(2)) bus();

    predictor_update_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [32:0] q[$];
    logic        m_rr  = 1'b0;
    logic        m_upd = 1'b0;
    logic [31:0] m_pc  = '0;
    logic        m_res = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic fl,
                        input logic av, input logic [31:0] apc, input logic at,
                        input logic bv, input logic [31:0] bpc, input logic bt);
        int          free;
        logic        both, open, acc_a, acc_b;
        logic [32:0] e;
        @(negedge clk);
        rst = r;
        bus.rdy = rd;
        bus.flush = fl;
        bus.a_valid = av;
        bus.a_pc = apc;
        bus.a_taken = at;
        bus.b_valid = bv;
        bus.b_pc = bpc;
        bus.b_taken = bt;
        #1;
        free = 4 - q.size();
        both = av & bv;
        open = r & rd & ~fl;
        acc_a = open && av && (free >= 2 || (free == 1 && (!both || !m_rr)));
        acc_b = open && bv && (free >= 2 || (free == 1 && (!both || m_rr)));
        if (!open || free == 0) begin
            check("a_ready_blocked", 64'(bus.a_ready), 64'(0));
            check("b_ready_blocked", 64'(bus.b_ready), 64'(0));
        end else begin
            check("a_accept", 64'(bus.a_ready & av), 64'(acc_a));
            check("b_accept", 64'(bus.b_ready & bv), 64'(acc_b));
        end
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            m_rr = 1'b0;
            m_upd = 1'b0;
            m_pc = '0;
            m_res = 1'b0;
        end else if (rd) begin
            if (fl) begin
                q.delete();
                m_upd = 1'b0;
            end else begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_upd = 1'b1;
                    m_pc = e[32:1];
                    m_res = e[0];
                end else begin
                    m_upd = 1'b0;
                end
                if (acc_a) q.push_back({apc, at});
                if (acc_b) q.push_back({bpc, bt});
                if (free == 1 && both) m_rr = ~m_rr;
            end
        end
        check("update", 64'(bus.update), 64'(m_upd));
        check("update_pc", 64'(bus.update_pc), 64'(m_pc));
        check("update_result", 64'(bus.update_result), 64'(m_res));
        check("count", 64'(bus.count), 64'(q.size()));
    endtask

    task automatic idle();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.rdy = 1'b0;
        bus.flush = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_pc = '0;
        bus.a_taken = 1'b0;
        bus.b_valid = 1'b0;
        bus.b_pc = '0;
        bus.b_taken = 1'b0;
        step(0, 0, 0, 1, 32'h44, 1, 1, 32'h48, 1);
        step(0, 1, 0, 1, 32'h44, 1, 1, 32'h48, 1);
        check("reset_count", 64'(bus.count), 64'(0));
        check("reset_update_pc", 64'(bus.update_pc), 64'(0));

        step(1, 1, 0, 1, 32'h100, 1, 0, 0, 0);
        idle();
        check("single_update", 64'(bus.update), 64'(1));
        check("single_pc", 64'(bus.update_pc), 64'h100);
        check("single_result", 64'(bus.update_result), 64'(1));
        idle();
        check("single_done", 64'(bus.update), 64'(0));

        for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 32'h300 + 8 * i, i[0], 1, 32'h304 + 8 * i, ~i[0]);
        for (int i = 0; i < 6; i++) idle();

        step(1, 1, 0, 1, 32'h200, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'h210, 0, 0, 0, 0);
        step(1, 1, 0, 1, 32'h220, 1, 1, 32'h224, 0);
        step(1, 1, 0, 1, 32'h230, 0, 1, 32'h234, 1);
        step(1, 1, 0, 1, 32'h240, 1, 1, 32'h244, 1);
        step(1, 1, 1, 1, 32'h250, 1, 1, 32'h254, 1);
        check("flush_count", 64'(bus.count), 64'(0));
        for (int i = 0; i < 3; i++) idle();

        step(1, 1, 0, 1, 32'h400, 1, 1, 32'h404, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 32'h500, 1, 1, 32'h504, 1);
        idle();
        step(1, 1, 0, 1, 32'h600, 1, 1, 32'h604, 1);
        step(0, 1, 0, 1, 32'h700, 1, 1, 32'h704, 1);
        check("mid_drain_reset", 64'(bus.count), 64'(0));
        idle();

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 60) != 0, ($urandom % 5) != 0, ($urandom % 25) == 0,
                 ($urandom % 10) < 7, $urandom & 32'hFFFF_FFFC, 1'($urandom),
                 ($urandom % 10) < 6, $urandom & 32'hFFFF_FFFC, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
